// File: rtl/lighthouse_emitter.sv
// Lighthouse base-station frame generator: sync A, optional sync B, then a sweep
// pulse centred on a programmed delay, all on one active-low envelope line.
module lighthouse_emitter #(
  parameter int COUNTER_WIDTH = 32,
  parameter int CLOCKS_PER_US = 16,
  parameter int SYNC_GAP_US   = 400
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] sync_A_width,
  input  logic [COUNTER_WIDTH-1:0] sync_B_width,
  input  logic [COUNTER_WIDTH-1:0] sweep_delay,
  input  logic [COUNTER_WIDTH-1:0] sweep_width,
  output logic                     envelope,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_error
);

  localparam int XW = COUNTER_WIDTH + 2;
  localparam logic [XW-1:0] SYNC_GAP = XW'(SYNC_GAP_US * CLOCKS_PER_US);
  localparam logic [XW-1:0] ONE      = XW'(1);
  localparam logic [XW-1:0] ZERO     = {XW{1'b0}};

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SYNC_A     = 3'd1;
  localparam logic [2:0] S_GAP        = 3'd2;
  localparam logic [2:0] S_SYNC_B     = 3'd3;
  localparam logic [2:0] S_WAIT_SWEEP = 3'd4;
  localparam logic [2:0] S_SWEEP      = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [XW-1:0] t_q, t_d;
  logic [XW-1:0] a_last_q, a_last_d;
  logic [XW-1:0] gap_last_q, gap_last_d;
  logic [XW-1:0] b_last_q, b_last_d;
  logic [XW-1:0] pre_last_q, pre_last_d;
  logic [XW-1:0] sw_last_q, sw_last_d;
  logic          b_zero_q, b_zero_d;
  logic          envelope_q, envelope_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_error_q, cfg_error_d;

  logic [XW-1:0] a_x, b_x, d_x, w_x, half_x, b_end_x, s_start_x;
  logic          reject_s;

  // Widened frame geometry and acceptance check for the live config inputs
  always_comb begin
    a_x       = {2'b00, sync_A_width};
    b_x       = {2'b00, sync_B_width};
    d_x       = {2'b00, sweep_delay};
    w_x       = {2'b00, sweep_width};
    half_x    = w_x >> 1;
    b_end_x   = (b_x != ZERO) ? (a_x + SYNC_GAP + b_x) : a_x;
    s_start_x = d_x - half_x;
    reject_s  = (a_x == ZERO) || (w_x == ZERO) || (d_x < half_x) ||
                (s_start_x < (b_end_x + ONE));
  end

  // Frame sequencing; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    a_last_d    = a_last_q;
    gap_last_d  = gap_last_q;
    b_last_d    = b_last_q;
    pre_last_d  = pre_last_q;
    sw_last_d   = sw_last_q;
    b_zero_d    = b_zero_q;
    cfg_error_d = 1'b0;

    if (state_q != S_IDLE) begin
      t_d = t_q + ONE;
    end else begin
      t_d = t_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reject_s) begin
            cfg_error_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d    = S_SYNC_A;
            t_d        = ZERO;
            a_last_d   = a_x - ONE;
            gap_last_d = a_x + SYNC_GAP - ONE;
            b_last_d   = b_end_x - ONE;
            pre_last_d = s_start_x - ONE;
            sw_last_d  = s_start_x + w_x - ONE;
            b_zero_d   = (b_x == ZERO);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SYNC_A: begin
        if (t_q == a_last_q) begin
          state_d = S_GAP;
        end else begin
          state_d = S_SYNC_A;
        end
      end
      S_GAP: begin
        // Without sync B the sweep may legally start inside the gap
        if (b_zero_q && (t_q == pre_last_q)) begin
          state_d = S_SWEEP;
        end else if (t_q == gap_last_q) begin
          state_d = b_zero_q ? S_WAIT_SWEEP : S_SYNC_B;
        end else begin
          state_d = S_GAP;
        end
      end
      S_SYNC_B: begin
        if (t_q == b_last_q) begin
          state_d = S_WAIT_SWEEP;
        end else begin
          state_d = S_SYNC_B;
        end
      end
      S_WAIT_SWEEP: begin
        if (t_q == pre_last_q) begin
          state_d = S_SWEEP;
        end else begin
          state_d = S_WAIT_SWEEP;
        end
      end
      S_SWEEP: begin
        if (t_q == sw_last_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SWEEP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    envelope_d = !((state_d == S_SYNC_A) || (state_d == S_SYNC_B) || (state_d == S_SWEEP));
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers; reset forces the envelope high immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      t_q         <= ZERO;
      a_last_q    <= ZERO;
      gap_last_q  <= ZERO;
      b_last_q    <= ZERO;
      pre_last_q  <= ZERO;
      sw_last_q   <= ZERO;
      b_zero_q    <= 1'b1;
      envelope_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      a_last_q    <= a_last_d;
      gap_last_q  <= gap_last_d;
      b_last_q    <= b_last_d;
      pre_last_q  <= pre_last_d;
      sw_last_q   <= sw_last_d;
      b_zero_q    <= b_zero_d;
      envelope_q  <= envelope_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign envelope  = envelope_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_error = cfg_error_q;

endmodule

// File: tb/tb_lighthouse_emitter.sv
// Scoreboard bench for lighthouse_emitter: expected edge/pulse events are queued
// with absolute cycle numbers at launch and matched as the DUT produces them.
module tb_lighthouse_emitter;

  localparam int CW  = 32;
  localparam int GAP = 16 * 400;

  localparam int EV_BUSY_RISE = 0;
  localparam int EV_ENV_FALL  = 1;
  localparam int EV_ENV_RISE  = 2;
  localparam int EV_DONE      = 3;
  localparam int EV_CFG_ERR   = 4;
  localparam int EV_BUSY_FALL = 5;
  localparam int NO_LIMIT     = 32'h7fff_ffff;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] sync_A_width, sync_B_width, sweep_delay, sweep_width;
  logic          envelope, busy, done, cfg_error;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  ev_t sb[$];
  bit  env_p  = 1'b1;
  bit  busy_p = 1'b0;

  lighthouse_emitter dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sync_A_width (sync_A_width),
    .sync_B_width (sync_B_width),
    .sweep_delay  (sweep_delay),
    .sweep_width  (sweep_width),
    .envelope     (envelope),
    .busy         (busy),
    .done         (done),
    .cfg_error    (cfg_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic got_ev(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      check_eq("spurious_event_kind", kind, -1);
    end else begin
      e = sb.pop_front();
      check_eq("event_kind", kind, e.kind);
      check_eq("event_cycle", cyc, e.cyc);
    end
  endtask

  // Same-cycle events are reported in a fixed order that the model follows
  always @(negedge clk) begin
    if (busy === 1'b1 && !busy_p) got_ev(EV_BUSY_RISE);
    if (envelope === 1'b0 && env_p) got_ev(EV_ENV_FALL);
    if (envelope === 1'b1 && !env_p) got_ev(EV_ENV_RISE);
    if (done === 1'b1) got_ev(EV_DONE);
    if (cfg_error === 1'b1) got_ev(EV_CFG_ERR);
    if (busy === 1'b0 && busy_p) got_ev(EV_BUSY_FALL);
    env_p  <= (envelope === 1'b1);
    busy_p <= (busy === 1'b1);
  end

  task automatic push_ev(input int kind, input int c, input int limit);
    ev_t e;
    if (c < limit) begin
      e.kind = kind;
      e.cyc  = c;
      sb.push_back(e);
    end
  endtask

  // Reference model: start sampled at edge k, t=0 is the cycle after that edge
  task automatic model_frame(input int a, input int b, input int d, input int w,
                             input int k, input int limit);
    int half, bend, s;
    half = w / 2;
    bend = (b != 0) ? a + GAP + b : a;
    s    = d - half;
    if (a == 0 || w == 0 || d < half || s < bend + 1) begin
      push_ev(EV_CFG_ERR, k, limit);
    end else begin
      push_ev(EV_BUSY_RISE, k, limit);
      push_ev(EV_ENV_FALL, k, limit);
      push_ev(EV_ENV_RISE, k + a, limit);
      if (b != 0) begin
        push_ev(EV_ENV_FALL, k + a + GAP, limit);
        push_ev(EV_ENV_RISE, k + bend, limit);
      end
      push_ev(EV_ENV_FALL, k + s, limit);
      push_ev(EV_ENV_RISE, k + s + w, limit);
      push_ev(EV_DONE, k + s + w, limit);
      push_ev(EV_BUSY_FALL, k + s + w + 1, limit);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_cfg(input int a, input int b, input int d, input int w);
    sync_A_width = a;
    sync_B_width = b;
    sweep_delay  = d;
    sweep_width  = w;
  endtask

  task automatic run_frame(input int a, input int b, input int d, input int w);
    set_cfg(a, b, d, w);
    start = 1'b1;
    model_frame(a, b, d, w, cyc + 1, NO_LIMIT);
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("drain_pending_events", sb.size(), 0);
    repeat (20) tick();
  endtask

  initial begin
    int k1, k2;
    reset = 1'b1;
    start = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (4) tick();
    check_eq("reset_envelope", envelope, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_cfg_error", cfg_error, 0);
    reset = 1'b0;
    repeat (3) tick();

    // Nominal frame with sync B
    run_frame(1000, 1100, 20000, 160);
    drain(21000);

    // No sync B, odd sweep width
    run_frame(1500, 0, 9000, 161);
    drain(10000);

    // Rejected configurations
    run_frame(0, 0, 9000, 161);
    drain(10);
    run_frame(1000, 0, 9000, 0);
    drain(10);
    run_frame(1000, 1100, 8500, 2);
    drain(10);
    run_frame(10, 0, 10, 40);
    drain(10);

    // Boundary accept with start held high: back-to-back frames, config changed mid-frame
    set_cfg(1000, 1100, 8502, 2);
    start = 1'b1;
    k1 = cyc + 1;
    k2 = k1 + 8501 + 2 + 2;
    model_frame(1000, 1100, 8502, 2, k1, NO_LIMIT);
    model_frame(1000, 1100, 8502, 2, k2, NO_LIMIT);
    while (cyc < k2) tick();
    start = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (100) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(9000);

    // Asynchronous reset in the middle of the sweep: no done pulse may follow
    set_cfg(1500, 0, 9000, 161);
    start = 1'b1;
    k1 = cyc + 1;
    model_frame(1500, 0, 9000, 161, k1, k1 + 8971);
    tick();
    start = 1'b0;
    while (cyc < k1 + 8970) tick();
    #1 reset = 1'b1;
    #1;
    check_eq("async_reset_envelope", envelope, 1);
    check_eq("async_reset_busy", busy, 0);
    push_ev(EV_ENV_RISE, k1 + 8971, NO_LIMIT);
    push_ev(EV_BUSY_FALL, k1 + 8971, NO_LIMIT);
    repeat (3) tick();
    reset = 1'b0;
    drain(20);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
